// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: accepts one load/store at a time on a
// req/ready handshake and completes it with a single-cycle ack after LATENCY cycles.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h10010000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           cap_we;
  logic [31:0]    cap_addr;
  logic [31:0]    cap_wdata;
  logic [31:0]    mem [DEPTH];

  logic           acc_we_c;
  logic [31:0]    acc_addr_c;
  logic [31:0]    acc_wdata_c;
  logic [31:0]    off_c;
  logic           fault_c;
  logic           enter_resp_c;
  logic [AW-1:0]  idx_c;

  // With LATENCY==1 the access happens at the acceptance edge, so use the live inputs there.
  always_comb begin
    acc_we_c    = cap_we;
    acc_addr_c  = cap_addr;
    acc_wdata_c = cap_wdata;
    if (state == IDLE) begin
      acc_we_c    = we;
      acc_addr_c  = addr;
      acc_wdata_c = wdata;
    end
    off_c   = acc_addr_c - BASE;
    fault_c = (acc_addr_c[1:0] != 2'b00) || (acc_addr_c < BASE) || ({1'b0, off_c} >= SPAN);
    idx_c   = off_c[AW+1:2];
    enter_resp_c = 1'b0;
    case (state)
      IDLE:    enter_resp_c = req && (LATENCY == 32'd1);
      WAIT:    enter_resp_c = (cnt == CW'(1));
      default: enter_resp_c = 1'b0;
    endcase
  end

  // Storage is never cleared; a reset at the RESP-entry edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp_c && acc_we_c && !fault_c) begin
      mem[idx_c] <= acc_wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            ready     <= 1'b0;
            state     <= WAIT;
            cnt       <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
      if (enter_resp_c) begin
        state <= RESP;
        ack   <= 1'b1;
        err   <= fault_c;
        rdata <= (!fault_c && !acc_we_c) ? mem[idx_c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected {rdata, err}; monitors pop and compare on each ack.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h10010000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic        ready_a, ack_a, err_a;
  logic [31:0] rdata_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic        ready_b, ack_b, err_b;
  logic [31:0] rdata_b;

  data_mem_responder #(.DEPTH(1024), .BASE(BASE), .LATENCY(2)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ready(ready_a), .ack(ack_a), .rdata(rdata_a), .err(err_a));

  data_mem_responder #(.DEPTH(16), .BASE(BASE), .LATENCY(1)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ready(ready_b), .ack(ack_b), .rdata(rdata_b), .err(err_b));

  int n_cmp = 0;
  int n_bad = 0;
  int acks_a = 0;
  int acks_b = 0;
  bit armed = 1'b0;
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A (LATENCY=2)
  always @(negedge clk) begin
    if (armed) begin
      if (ack_a) begin
        acks_a++;
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack_a: got ack with empty scoreboard at %0t", $time);
        end else begin
          logic [32:0] e;
          e = q_a.pop_front();
          check("rdata_a", 64'(rdata_a), 64'(e[32:1]));
          check("err_a", 64'(err_a), 64'(e[0]));
        end
      end else begin
        check("idle_zero_a", 64'({rdata_a, err_a}), 64'(0));
      end
    end
  end

  // Monitor for instance B (LATENCY=1)
  always @(negedge clk) begin
    if (armed) begin
      if (ack_b) begin
        acks_b++;
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack_b: got ack with empty scoreboard at %0t", $time);
        end else begin
          logic [32:0] e;
          e = q_b.pop_front();
          check("rdata_b", 64'(rdata_b), 64'(e[32:1]));
          check("err_b", 64'(err_b), 64'(e[0]));
        end
      end else begin
        check("idle_zero_b", 64'({rdata_b, err_b}), 64'(0));
      end
    end
  end

  task automatic wait_ready_a();
    int n = 0;
    while (!ready_a && n < 50) begin @(negedge clk); n++; end
    check("ready_wait_a", 64'(ready_a), 64'(1));
  endtask

  // Issue one transaction on A from a negedge; returns at the negedge after ack.
  task automatic issue_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
    int n;
    wait_ready_a();
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    q_a.push_back({exp_rd, exp_err});
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    n = 1;
    while (!ack_a && n < 20) begin @(negedge clk); n++; end
    check("latency_a", 64'(n), 64'(2));
    @(negedge clk);
    check("ready_after_ack_a", 64'(ready_a), 64'(1));
  endtask

  task automatic issue_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    while (!ready_b && n < 50) begin @(negedge clk); n++; end
    check("ready_wait_b", 64'(ready_b), 64'(1));
    req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
    q_b.push_back({exp_rd, exp_err});
    @(posedge clk);
    @(negedge clk);
    req_b = 1'b0;
    check("latency_b_ack", 64'(ack_b), 64'(1));
    @(negedge clk);
    check("ready_after_ack_b", 64'(ready_b), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base_acks;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", 64'({ready_a, ack_a, err_a, rdata_a}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    check("reset_b", 64'({ready_b, ack_b, err_b, rdata_b}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    reset = 1'b1;
    armed = 1'b1;
    @(negedge clk);

    // Known contents for later readback
    issue_a(1'b1, BASE,              32'h11111111, 32'h0, 1'b0);
    issue_a(1'b1, BASE + 32'd4092,   32'h22222222, 32'h0, 1'b0);
    issue_a(1'b1, BASE + 32'd4,      32'hA5A5A5A5, 32'h0, 1'b0);
    issue_a(1'b1, BASE + 32'd12,     32'h0C0C0C0C, 32'h0, 1'b0);

    // Store then immediate load of the same word
    issue_a(1'b1, 32'h10010008, 32'hDEADBEEF, 32'h0, 1'b0);
    issue_a(1'b0, 32'h10010008, 32'h0, 32'hDEADBEEF, 1'b0);

    // Faults: misaligned, below BASE, one past the end
    issue_a(1'b0, 32'h10010002, 32'h0, 32'h0, 1'b1);
    issue_a(1'b1, 32'h0FFFFFFC, 32'hBAD0BAD0, 32'h0, 1'b1);
    issue_a(1'b1, BASE + 32'd4096, 32'hBAD1BAD1, 32'h0, 1'b1);
    issue_a(1'b0, BASE, 32'h0, 32'h11111111, 1'b0);
    issue_a(1'b0, BASE + 32'd4092, 32'h0, 32'h22222222, 1'b0);

    // Busy ignore: req held with different addr/wdata during WAIT/RESP
    wait_ready_a();
    base_acks = acks_a;
    req_a = 1'b1; we_a = 1'b1; addr_a = BASE + 32'd8; wdata_a = 32'hCAFEF00D;
    q_a.push_back({32'h0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    addr_a = BASE + 32'd12; wdata_a = 32'h99999999;
    check("busy_ready_low", 64'(ready_a), 64'(0));
    @(negedge clk);
    check("busy_ack", 64'(ack_a), 64'(1));
    req_a = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_one_ack", 64'(acks_a - base_acks), 64'(1));
    issue_a(1'b0, BASE + 32'd8,  32'h0, 32'hCAFEF00D, 1'b0);
    issue_a(1'b0, BASE + 32'd12, 32'h0, 32'h0C0C0C0C, 1'b0);

    // Reset lands on the edge that would enter RESP
    wait_ready_a();
    base_acks = acks_a;
    req_a = 1'b1; we_a = 1'b1; addr_a = BASE + 32'd4; wdata_a = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_a), 64'(1));
    check("rst_no_ack", 64'(ack_a), 64'(0));
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ack_count", 64'(acks_a - base_acks), 64'(0));
    issue_a(1'b0, BASE + 32'd4, 32'h0, 32'hA5A5A5A5, 1'b0);

    // LATENCY=1: req held high gives an ack every second cycle
    base_acks = acks_b;
    req_b = 1'b1; we_b = 1'b1; addr_b = BASE; wdata_b = 32'h5;
    repeat (4) q_b.push_back({32'h0, 1'b0});
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ack", 64'(ack_b), 64'((i % 2) == 0));
      if (i == 6) req_b = 1'b0;
    end
    @(negedge clk);
    check("b2b_ack_count", 64'(acks_b - base_acks), 64'(4));
    issue_b(1'b0, BASE, 32'h0, 32'h5, 1'b0);
    issue_b(1'b1, BASE + 32'd60, 32'h00000001, 32'h0, 1'b0);
    issue_b(1'b0, BASE + 32'd60, 32'h0, 32'h00000001, 1'b0);
    issue_b(1'b1, BASE + 32'd64, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue_b(1'b0, BASE + 32'd60, 32'h0, 32'h00000001, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_a_drained", 64'(q_a.size()), 64'(0));
    check("sb_b_drained", 64'(q_b.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
